// File: rtl/axis_pkg.sv
// Shared widths, counter sizes and packet-tracking state for the AXI-stream packet monitor.
package axis_pkg;
  localparam int W_DATA_DEF = 512;
  localparam int W_USER_DEF = 48;
  localparam int PKT_CNT_W  = 32;
  localparam int BYTE_CNT_W = 48;
  localparam int LEN_W      = 16;
  localparam int ERR_CNT_W  = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_t;
endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream skid buffer: registered m_* and s_tready, 1-cycle latency when empty.
// s_tready drops only while both entries are occupied; m_* hold while stalled.
module axis_skid_buf
  import axis_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  parameter int W_USER = W_USER_DEF,
  localparam int W_KEEP = W_DATA / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_tvalid,
  input  logic [W_DATA-1:0] s_tdata,
  input  logic [W_KEEP-1:0] s_tkeep,
  input  logic              s_tlast,
  input  logic [W_USER-1:0] s_tuser,
  output logic              s_tready,
  output logic              m_tvalid,
  output logic [W_DATA-1:0] m_tdata,
  output logic [W_KEEP-1:0] m_tkeep,
  output logic              m_tlast,
  output logic [W_USER-1:0] m_tuser,
  input  logic              m_tready
);
  logic              skid_vld;
  logic              skid_vld_nxt;
  logic [W_DATA-1:0] skid_data;
  logic [W_KEEP-1:0] skid_keep;
  logic              skid_last;
  logic [W_USER-1:0] skid_user;
  logic              accept;

  assign accept = s_tvalid & s_tready;

  // Skid slot fills only when the output register is stalled; otherwise it drains into m_*.
  always_comb begin
    skid_vld_nxt = 1'b0;
    if (m_tvalid && !m_tready) begin
      skid_vld_nxt = skid_vld | accept;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tkeep   <= '0;
      m_tlast   <= 1'b0;
      m_tuser   <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_keep <= '0;
      skid_last <= 1'b0;
      skid_user <= '0;
    end else begin
      skid_vld <= skid_vld_nxt;
      s_tready <= !skid_vld_nxt;
      if (!m_tvalid || m_tready) begin
        if (skid_vld) begin
          m_tvalid <= 1'b1;
          m_tdata  <= skid_data;
          m_tkeep  <= skid_keep;
          m_tlast  <= skid_last;
          m_tuser  <= skid_user;
        end else if (accept) begin
          m_tvalid <= 1'b1;
          m_tdata  <= s_tdata;
          m_tkeep  <= s_tkeep;
          m_tlast  <= s_tlast;
          m_tuser  <= s_tuser;
        end else begin
          m_tvalid <= 1'b0;
        end
      end else if (accept) begin
        skid_data <= s_tdata;
        skid_keep <= s_tkeep;
        skid_last <= s_tlast;
        skid_user <= s_tuser;
      end
    end
  end
endmodule

// File: rtl/axis_pkt_monitor.sv
// Pass-through AXI-stream monitor (skid buffer, 1-cycle latency) with packet/byte statistics on accepted beats.
// Define AXIS_PKT_MONITOR_KEEP_CHECK_EN to enable tkeep protocol-error counting; stats never backpressure.
module axis_pkt_monitor
  import axis_pkg::*;
#(
  parameter int W_DATA = W_DATA_DEF,
  parameter int W_USER = W_USER_DEF,
  localparam int W_KEEP = W_DATA / 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_tvalid,
  input  logic [W_DATA-1:0]     s_tdata,
  input  logic [W_KEEP-1:0]     s_tkeep,
  input  logic                  s_tlast,
  input  logic [W_USER-1:0]     s_tuser,
  output logic                  s_tready,
  output logic                  m_tvalid,
  output logic [W_DATA-1:0]     m_tdata,
  output logic [W_KEEP-1:0]     m_tkeep,
  output logic                  m_tlast,
  output logic [W_USER-1:0]     m_tuser,
  input  logic                  m_tready,
  input  logic                  stats_clr,
  output logic [PKT_CNT_W-1:0]  pkt_cnt,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic [LEN_W-1:0]      last_pkt_len,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic                  err_sticky
);
  logic             accept;
  logic [LEN_W-1:0] beat_bytes;
  logic [LEN_W:0]   run_sum;
  logic [LEN_W-1:0] run_sat;
  logic [LEN_W-1:0] running;
  pkt_state_t       state, state_nxt;

  axis_skid_buf #(
    .W_DATA(W_DATA),
    .W_USER(W_USER)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .s_tvalid(s_tvalid),
    .s_tdata (s_tdata),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .s_tuser (s_tuser),
    .s_tready(s_tready),
    .m_tvalid(m_tvalid),
    .m_tdata (m_tdata),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast),
    .m_tuser (m_tuser),
    .m_tready(m_tready)
  );

  assign accept = s_tvalid & s_tready;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < W_KEEP; i++) begin
      beat_bytes = beat_bytes + LEN_W'(s_tkeep[i]);
    end
  end

  assign run_sum = {1'b0, running} + {1'b0, beat_bytes};
  assign run_sat = run_sum[LEN_W] ? '1 : run_sum[LEN_W-1:0];

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = s_tlast ? ST_IDLE : ST_IN_PKT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      running <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        running <= s_tlast ? '0 : run_sat;
      end
    end
  end

  // A clear in the same cycle as an accepted beat leaves only that beat's contribution.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_cnt      <= '0;
      byte_cnt     <= '0;
      last_pkt_len <= '0;
    end else begin
      if (stats_clr) begin
        pkt_cnt      <= '0;
        byte_cnt     <= '0;
        last_pkt_len <= '0;
      end
      if (accept) begin
        byte_cnt <= (stats_clr ? '0 : byte_cnt) + BYTE_CNT_W'(beat_bytes);
        if (s_tlast) begin
          pkt_cnt      <= (stats_clr ? '0 : pkt_cnt) + 1'b1;
          last_pkt_len <= run_sat;
        end
      end
    end
  end

`ifdef AXIS_PKT_MONITOR_KEEP_CHECK_EN
  logic                 keep_err;
  logic [ERR_CNT_W-1:0] err_base;

  // Contiguous-from-bit-0 masks have no set bit above a clear bit: k & (k+1) == 0.
  always_comb begin
    keep_err = (s_tkeep == '0)
            || ((s_tkeep & (s_tkeep + W_KEEP'(1))) != '0)
            || (!s_tlast && (s_tkeep != '1));
  end

  assign err_base = stats_clr ? '0 : err_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (stats_clr) begin
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end
      if (accept && keep_err) begin
        err_cnt    <= (err_base == '1) ? err_base : err_base + 1'b1;
        err_sticky <= 1'b1;
      end
    end
  end
`else
  assign err_cnt    = '0;
  assign err_sticky = 1'b0;
`endif
endmodule
